ro_freq_meter: RTL and testbench
================================

Name: ro_freq_meter

Overview:
- Gated edge counter that measures the frequency of one ring-oscillator output after it has passed through the 16:1 oscillator select mux.
- Counts rising edges of the synchronized `ro_in` over a programmable window of `wb_clk_i` cycles.
- Result is read back over the Wishbone slave port, giving on-chip characterization with no external frequency counter.
- Also drives the mux select code (`sel_o`) and oscillator enable (`start_o`) so firmware can sweep all oscillators.

Parameters:
- CNT_W, 32: width of the edge counter and the COUNT register.
- WIN_W, 24: width of the gate-window length register.
- SYNC_STAGES, 2: flip-flop stages in the `ro_in` synchronizer; legal values 2..4.
- BASE_ADDR, 32'h3000_0000: Wishbone base address; bits [31:4] are decoded.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, asynchronous assert, active-high.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte lane selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- ro_in  in  1  muxed oscillator output, asynchronous to `wb_clk_i`.
- sel_o  out  4  oscillator mux select code.
- start_o  out  1  oscillator enable.

Behaviour:
- Register map (word offsets):
  - 0x0 CTRL: [0] GO, write-1, self-clearing, reads 0. [1] CONT, auto-rearm. [2] RUN, drives `start_o`. [7:4] SEL, drives `sel_o`.
  - 0x4 WINDOW: [WIN_W-1:0] gate length in clocks.
  - 0x8 COUNT: read-only latched result.
  - 0xC STATUS: [0] BUSY. [1] DONE, write-1-to-clear. [2] OVF, write-1-to-clear.
  - Unmapped offsets read 0; writes to them are ignored.
- Wishbone timing:
  - A transfer is a request when stb & cyc & address match.
  - `wbs_ack_o` asserts for exactly 1 cycle, 1 cycle after the request is seen.
  - ack is not reasserted while stb stays high after an ack; the next transfer needs stb to drop.
  - Writes honour `wbs_sel_i` byte lanes. `wbs_dat_o` is valid during ack and is 0 otherwise.
- Reset values:
  - All registers 0. `sel_o` = 0, `start_o` = 0, ack = 0, `wbs_dat_o` = 0. FSM in IDLE.
  - The synchronizer chain and edge-detect flop reset to 0.
- Input conditioning:
  - `ro_in` passes through SYNC_STAGES flops, then an edge-detect flop.
  - A rising edge is sync = 1 and previous sample = 0.
  - Measurement is guaranteed only for f_ro < f_clk/2; faster inputs alias, and this is documented as not detected.
- FSM states:
  - IDLE: BUSY = 0. GO = 1 → ARM, unless WINDOW = 0, in which case it stays in IDLE and sets DONE with COUNT = 0.
  - ARM: lasts SYNC_STAGES+1 cycles to flush stale synchronizer state. Clears the edge counter, loads the window counter with WINDOW, then → GATE.
  - GATE: decrements the window counter each cycle and increments the edge counter on each detected edge.
    - The edge counter saturates at all-ones and sets a sticky internal overflow flag.
    - When the window counter reaches 1, the final cycle's edge still counts → DONE.
    - The gate is therefore exactly WINDOW cycles long.
  - DONE: 1 cycle. Latches COUNT, sets the DONE bit, and sets OVF if overflow occurred. Then → ARM if CONT = 1, else → IDLE.
- BUSY = 1 in ARM, GATE and DONE.
- Simultaneous and mid-measurement events:
  - GO while BUSY is ignored.
  - A WINDOW or SEL write while BUSY takes effect in the register immediately. `sel_o` changes immediately; the current result is not invalidated and firmware is responsible.
  - Clearing CONT while in GATE ends the sequence after the current window.
  - A hardware DONE set and a firmware W1C in the same cycle: the set wins.
  - Asserting `wb_rst_i` mid-GATE aborts immediately to the reset values; COUNT is lost.
- Latency: GO write ack → DONE set takes 1 + (SYNC_STAGES+1) + WINDOW + 1 cycles.

Optional Feature:
- Macro: RO_FREQ_IRQ_EN.
- When defined:
  - Adds output port `irq_o` (1 bit) and register 0x10 IRQ_EN ([0] enable).
  - `irq_o` = DONE & IRQ_EN[0], registered; it deasserts on the cycle after DONE is cleared.
- When undefined:
  - No `irq_o` port; offset 0x10 is unmapped and reads 0.

Test Plan:
- Reset and idle readback: assert `wb_rst_i` mid-cycle, then release → reads of CTRL/WINDOW/COUNT/STATUS all return 0; `sel_o` = 0, `start_o` = 0; every read is acked in exactly 1 cycle.
- Basic measurement: `ro_in` at period 10 clk, WINDOW = 1000, GO → BUSY = 1; DONE at 1000 + SYNC_STAGES + 3 cycles after the ack; COUNT = 100 ± 1.
- Zero and short windows:
  - WINDOW = 0, GO → DONE set immediately, COUNT = 0, BUSY never set.
  - WINDOW = 1, `ro_in` edge aligned into the gate cycle → COUNT = 1.
- Overflow: CNT_W overridden to 8, `ro_in` period 4, WINDOW = 2000 → COUNT = 255, OVF = 1. W1C to STATUS → OVF = 0 and DONE = 0.
- Continuous mode and reset abort: CONT = 1, WINDOW = 100, period 5 → COUNT refreshes to 20 every 100 + SYNC_STAGES + 2 cycles. Assert reset in mid-GATE → BUSY = 0 and COUNT = 0 after release.
- Select and IRQ: write SEL = 0xA, RUN = 1 → `sel_o` = 4'hA, `start_o` = 1. With RO_FREQ_IRQ_EN and IRQ_EN = 1: completion → `irq_o` = 1; W1C of DONE → `irq_o` = 0 on the next cycle.

Source files
------------

// File: rtl/ro_freq_meter.sv
// ro_freq_meter: gated edge counter for one muxed ring-oscillator output.
// Counts rising edges of a synchronized ro_in over a programmable window of
// wb_clk_i cycles and exposes control/result registers on a Wishbone slave.
// Optional macro RO_FREQ_IRQ_EN adds irq_o and the IRQ_EN register (0x10).
//
// Bus handshake: a request is stb & cyc & address match. The request is
// sampled on a clock edge and wbs_ack_o is high for the following cycle
// only. While stb stays high after an ack no further ack is issued; the
// master must drop stb for at least one clock edge before the next transfer.
// wbs_dat_o carries read data during the ack cycle and is 0 otherwise.
module ro_freq_meter #(
    parameter int          CNT_W       = 32,
    parameter int          WIN_W       = 24,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        ro_in,
    output logic [3:0]  sel_o,
    output logic        start_o
`ifdef RO_FREQ_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    // Word offsets inside the register window.
    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_WINDOW = 3'd1;
    localparam logic [2:0] OFF_COUNT  = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
`ifdef RO_FREQ_IRQ_EN
    localparam logic [2:0] OFF_IRQ_EN = 3'd4;
    localparam int         DEC_LO     = 5;
`else
    localparam int         DEC_LO     = 4;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_GATE,
        S_DONE
    } state_t;

    // Bus decode
    logic        req;
    logic        ack_issue;
    logic        served;
    logic        wr;
    logic [2:0]  offset;
    logic [31:0] rd_data;
    logic [31:0] win_ext;
    logic [31:0] win_merge;

    // Firmware-visible control
    logic             go_pulse;
    logic             cont;
    logic             run;
    logic [3:0]       osc_sel;
    logic [WIN_W-1:0] window;
    logic             done_clr;
    logic             ovf_clr;
`ifdef RO_FREQ_IRQ_EN
    logic             irq_en;
`endif

    // Measurement datapath
    state_t                   state;
    logic [2:0]               arm_cnt;
    logic [WIN_W-1:0]         win_cnt;
    logic [CNT_W-1:0]         edge_cnt;
    logic                     ovf_flag;
    logic [CNT_W-1:0]         count;
    logic                     done_bit;
    logic                     ovf_bit;
    logic                     busy;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     prev_q;
    logic                     rise;

    logic unused;
    assign unused = &{1'b0, wbs_adr_i[1:0], win_merge};

    assign sel_o   = osc_sel;
    assign start_o = run;
    assign busy    = (state != S_IDLE);
    assign rise    = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign win_ext = 32'(window);

    // Request decode, single-shot ack qualification and W1C strobes.
    always_comb begin
        req       = wbs_stb_i & wbs_cyc_i &
                    (wbs_adr_i[31:DEC_LO] == BASE_ADDR[31:DEC_LO]);
        ack_issue = req & ~wbs_ack_o & ~served;
        wr        = ack_issue & wbs_we_i;
`ifdef RO_FREQ_IRQ_EN
        offset    = wbs_adr_i[4:2];
`else
        offset    = {1'b0, wbs_adr_i[3:2]};
`endif
        done_clr  = wr & (offset == OFF_STATUS) & wbs_sel_i[0] & wbs_dat_i[1];
        ovf_clr   = wr & (offset == OFF_STATUS) & wbs_sel_i[0] & wbs_dat_i[2];
    end

    // Byte-lane merge of write data into the current WINDOW value.
    always_comb begin
        win_merge = win_ext;
        for (int i = 0; i < 4; i++) begin
            if (wbs_sel_i[i]) begin
                win_merge[8*i +: 8] = wbs_dat_i[8*i +: 8];
            end
        end
    end

    // Read-data mux; GO always reads back as 0, unmapped offsets read 0.
    always_comb begin
        rd_data = '0;
        case (offset)
            OFF_CTRL:   rd_data = {24'd0, osc_sel, 1'b0, run, cont, 1'b0};
            OFF_WINDOW: rd_data = win_ext;
            OFF_COUNT:  rd_data = 32'(count);
            OFF_STATUS: rd_data = {29'd0, ovf_bit, done_bit, busy};
`ifdef RO_FREQ_IRQ_EN
            OFF_IRQ_EN: rd_data = {31'd0, irq_en};
`endif
            default:    rd_data = '0;
        endcase
    end

    // Bus response: one-cycle ack, read data only during ack, stb-drop tracking.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            served    <= 1'b0;
        end else begin
            wbs_ack_o <= ack_issue;
            wbs_dat_o <= ack_issue ? rd_data : '0;
            served    <= req & (wbs_ack_o | served);
        end
    end

    // Control register writes; GO becomes a single-cycle pulse.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            go_pulse <= 1'b0;
            cont     <= 1'b0;
            run      <= 1'b0;
            osc_sel  <= '0;
            window   <= '0;
`ifdef RO_FREQ_IRQ_EN
            irq_en   <= 1'b0;
`endif
        end else begin
            go_pulse <= 1'b0;
            if (wr) begin
                case (offset)
                    OFF_CTRL: begin
                        if (wbs_sel_i[0]) begin
                            go_pulse <= wbs_dat_i[0];
                            cont     <= wbs_dat_i[1];
                            run      <= wbs_dat_i[2];
                            osc_sel  <= wbs_dat_i[7:4];
                        end
                    end
                    OFF_WINDOW: window <= win_merge[WIN_W-1:0];
`ifdef RO_FREQ_IRQ_EN
                    OFF_IRQ_EN: begin
                        if (wbs_sel_i[0]) begin
                            irq_en <= wbs_dat_i[0];
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // Synchronizer chain followed by the edge-detect sample.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Measurement FSM with result latch and sticky DONE/OVF status bits.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= S_IDLE;
            arm_cnt  <= '0;
            win_cnt  <= '0;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
            count    <= '0;
            done_bit <= 1'b0;
            ovf_bit  <= 1'b0;
        end else begin
            // Firmware clears first so a same-cycle hardware set wins.
            done_bit <= done_bit & ~done_clr;
            ovf_bit  <= ovf_bit & ~ovf_clr;
            case (state)
                S_IDLE: begin
                    if (go_pulse) begin
                        if (window == '0) begin
                            count    <= '0;
                            done_bit <= 1'b1;
                        end else begin
                            arm_cnt <= '0;
                            state   <= S_ARM;
                        end
                    end
                end
                S_ARM: begin
                    // Hold off SYNC_STAGES+1 cycles so stale synchronizer
                    // contents from a previous oscillator are flushed.
                    if (arm_cnt == 3'(SYNC_STAGES)) begin
                        edge_cnt <= '0;
                        ovf_flag <= 1'b0;
                        win_cnt  <= window;
                        state    <= S_GATE;
                    end else begin
                        arm_cnt <= arm_cnt + 3'd1;
                    end
                end
                S_GATE: begin
                    if (rise) begin
                        if (edge_cnt == '1) begin
                            ovf_flag <= 1'b1;
                        end else begin
                            edge_cnt <= edge_cnt + CNT_W'(1);
                        end
                    end
                    win_cnt <= win_cnt - WIN_W'(1);
                    // A window shrunk to 0 while busy still closes after one cycle.
                    if (win_cnt <= WIN_W'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    count    <= edge_cnt;
                    done_bit <= 1'b1;
                    if (ovf_flag) begin
                        ovf_bit <= 1'b1;
                    end
                    if (cont) begin
                        arm_cnt <= '0;
                        state   <= S_ARM;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef RO_FREQ_IRQ_EN
    // Registered interrupt: follows DONE gated by the enable bit.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= done_bit & irq_en;
        end
    end
`endif

endmodule

// File: tb/tb_ro_freq_meter.sv
// tb_ro_freq_meter: directed plus randomized checks of ro_freq_meter.
// Two instances share one Wishbone bus at different bases: a default one and
// one with CNT_W = 8 for saturation. ro_in is generated in step with the
// clock so the expected edge count follows from window and period alone.
`timescale 1ns/1ps
module tb_ro_freq_meter;

    localparam logic [31:0] B0 = 32'h3000_0000;
    localparam logic [31:0] B8 = 32'h3000_0100;
    localparam int          S  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stb, cyc, we;
    logic [3:0]  be;
    logic [31:0] dat_w, adr;
    logic        ack0, ack8;
    logic [31:0] dat0, dat8;
    logic        ro_in;
    logic [3:0]  sel0, sel8;
    logic        start0, start8;
`ifdef RO_FREQ_IRQ_EN
    logic        irq0, irq8;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_n = 0;
    int   last_ack = 0;
    int   ro_period = 0;
    logic ro_manual = 1'b0;

    ro_freq_meter #(.BASE_ADDR(B0)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(be),
        .wbs_dat_i(dat_w), .wbs_adr_i(adr), .wbs_ack_o(ack0), .wbs_dat_o(dat0),
        .ro_in(ro_in), .sel_o(sel0), .start_o(start0)
`ifdef RO_FREQ_IRQ_EN
        , .irq_o(irq0)
`endif
    );

    ro_freq_meter #(.CNT_W(8), .BASE_ADDR(B8)) dut8 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(be),
        .wbs_dat_i(dat_w), .wbs_adr_i(adr), .wbs_ack_o(ack8), .wbs_dat_o(dat8),
        .ro_in(ro_in), .sel_o(sel8), .start_o(start8)
`ifdef RO_FREQ_IRQ_EN
        , .irq_o(irq8)
`endif
    );

    // Clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Oscillator model: period in clocks, or a manual level when period is 0.
    initial begin
        int ph;
        ph = 0;
        ro_in = 1'b0;
        forever begin
            @(negedge clk);
            if (ro_period == 0) begin
                ro_in = ro_manual;
            end else begin
                ph = (ph + 1 >= ro_period) ? 0 : ph + 1;
                ro_in = (ph < ro_period / 2);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] r, output int ack_at);
        int n;
        @(negedge clk);
        adr = a; we = w; dat_w = d; be = b; stb = 1'b1; cyc = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(ack0 | ack8) && n < 10);
        r = dat0 | dat8;
        ack_at = cyc_n;
        check("ack_latency", n, 1);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("ack_single", {31'd0, ack0 | ack8}, 0);
        check("dat_idle", dat0 | dat8, 0);
    endtask

    task automatic wr_be(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] r;
        int t;
        xfer(a, 1'b1, d, b, r, t);
        last_ack = t;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_be(a, d, 4'hF);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] r);
        int t;
        xfer(a, 1'b0, 32'd0, 4'hF, r, t);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        rd(a, r);
        check(tag, r, exp);
    endtask

    task automatic wait_done(input string tag, input logic [31:0] base);
        logic [31:0] r;
        int k;
        r = '0;
        k = 0;
        while (r[1] == 1'b0 && k < 1500) begin
            rd(base + 32'hC, r);
            k++;
        end
        check({tag, "_done_seen"}, {31'd0, r[1]}, 1);
    endtask

    task automatic wait_until(input int target);
        while (cyc_n < target) begin
            @(posedge clk); #1;
        end
    endtask

    // Directed and randomized sequence
    initial begin
        logic [31:0] r;
        int a, p, w, lo, hi;
        logic [3:0] s;

        stb = 1'b0; cyc = 1'b0; we = 1'b0; be = '0; dat_w = '0; adr = '0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // Reset state
        rd_chk("rst_ctrl",   B0 + 32'h0, 32'h0);
        rd_chk("rst_window", B0 + 32'h4, 32'h0);
        rd_chk("rst_count",  B0 + 32'h8, 32'h0);
        rd_chk("rst_status", B0 + 32'hC, 32'h0);
        check("rst_sel_o",   {28'd0, sel0}, 0);
        check("rst_start_o", {31'd0, start0}, 0);

        // stb held after ack must not produce a second ack
        @(negedge clk);
        adr = B0 + 32'h4; we = 1'b0; be = 4'hF; stb = 1'b1; cyc = 1'b1;
        @(posedge clk); #1;
        check("hold_ack_first", {31'd0, ack0}, 1);
        @(posedge clk); #1;
        check("hold_ack_drop", {31'd0, ack0}, 0);
        @(posedge clk); #1;
        check("hold_ack_none", {31'd0, ack0}, 0);
        stb = 1'b0; cyc = 1'b0;
        @(posedge clk); #1;

        // Basic measurement: period 10, WINDOW 1000, exact DONE latency
        ro_period = 10;
        wr(B0 + 32'h4, 32'd1000);
        repeat (20) @(posedge clk);
        #1;
        wr(B0, 32'h1);
        a = last_ack;
        rd_chk("basic_busy", B0 + 32'hC, 32'h1);
        wr(B0, 32'h54);
        check("busy_sel_o", {28'd0, sel0}, 32'h5);
        check("busy_start_o", {31'd0, start0}, 1);
        wait_until(a + 1000 + S + 2);
        rd_chk("basic_not_done_yet", B0 + 32'hC, 32'h1);
        rd_chk("basic_done", B0 + 32'hC, 32'h2);
        rd_chk("basic_count", B0 + 32'h8, 32'd100);

        // WINDOW byte lanes: only lane 0 replaced (1000 = 0x3E8)
        wr_be(B0 + 32'h4, 32'hFFFF_FF07, 4'b0001);
        rd_chk("window_lane0", B0 + 32'h4, 32'h307);

        // Zero window: DONE at once with COUNT 0, never busy
        wr(B0 + 32'hC, 32'h6);
        wr(B0 + 32'h4, 32'd0);
        wr(B0, 32'h1);
        rd_chk("zero_win_status", B0 + 32'hC, 32'h2);
        rd_chk("zero_win_count", B0 + 32'h8, 32'd0);

        // One-cycle window with an edge placed into the gate cycle
        ro_period = 0;
        ro_manual = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        wr(B0 + 32'hC, 32'h6);
        wr(B0 + 32'h4, 32'd1);
        wr(B0, 32'h1);
        a = last_ack;
        wait_until(a + 2);
        ro_manual = 1'b1;
        wait_done("win1", B0);
        rd_chk("win1_count", B0 + 32'h8, 32'd1);
        wr(B0 + 32'hC, 32'h6);
        wr(B0, 32'h1);
        wait_done("win1_flat", B0);
        rd_chk("win1_flat_count", B0 + 32'h8, 32'd0);
        ro_manual = 1'b0;

        // Overflow on the 8-bit instance, then W1C of DONE and OVF
        ro_period = 4;
        repeat (20) @(posedge clk);
        #1;
        wr(B8 + 32'h4, 32'd2000);
        wr(B8, 32'h1);
        wait_done("ovf", B8);
        rd_chk("ovf_count", B8 + 32'h8, 32'hFF);
        rd_chk("ovf_status", B8 + 32'hC, 32'h6);
        wr(B8 + 32'hC, 32'h6);
        rd_chk("ovf_cleared", B8 + 32'hC, 32'h0);

        // Continuous mode, then CONT cleared, then reset abort mid-gate
        ro_period = 5;
        wr(B0 + 32'hC, 32'h6);
        wr(B0 + 32'h4, 32'd100);
        wr(B0, 32'h3);
        wait_done("cont1", B0);
        rd_chk("cont1_count", B0 + 32'h8, 32'd20);
        wr(B0 + 32'hC, 32'h2);
        wait_done("cont2", B0);
        rd_chk("cont2_count", B0 + 32'h8, 32'd20);
        rd(B0 + 32'hC, r);
        check("cont_still_busy", {31'd0, r[0]}, 1);
        wr(B0, 32'h0);
        repeat (250) @(posedge clk);
        #1;
        rd(B0 + 32'hC, r);
        check("cont_stopped", {31'd0, r[0]}, 0);
        wr(B0, 32'h3);
        a = last_ack;
        wait_until(a + S + 40);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        rd_chk("abort_status", B0 + 32'hC, 32'h0);
        rd_chk("abort_count",  B0 + 32'h8, 32'h0);
        rd_chk("abort_window", B0 + 32'h4, 32'h0);
        rd_chk("abort_ctrl",   B0 + 32'h0, 32'h0);

        // Randomized period/window against the edges-per-window model
        for (int i = 0; i < 6; i++) begin
            p = $urandom_range(3, 12);
            w = $urandom_range(20, 300);
            ro_period = p;
            repeat (20) @(posedge clk);
            #1;
            wr(B0 + 32'hC, 32'h6);
            wr(B0 + 32'h4, w);
            wr(B0, 32'h1);
            wait_done("rand", B0);
            rd(B0 + 32'h8, r);
            lo = w / p;
            hi = (w + p - 1) / p;
            n_cmp++;
            assert (int'(r) >= lo && int'(r) <= hi) else begin
                n_err++;
                $error("FAIL rand_count: observed %0d expected %0d..%0d (W=%0d P=%0d)", r, lo, hi, w, p);
            end
        end

        // Select and run, with GO reading back as 0
        wr(B0 + 32'h4, 32'd10);
        for (int i = 0; i < 3; i++) begin
            s = (i == 0) ? 4'hA : 4'($urandom_range(0, 15));
            wr(B0 + 32'hC, 32'h6);
            wr(B0, {24'd0, s, 4'b0101});
            check("sel_o", {28'd0, sel0}, {28'd0, s});
            check("start_o", {31'd0, start0}, 1);
            rd_chk("ctrl_readback", B0, {24'd0, s, 4'b0100});
            wait_done("sel", B0);
        end

`ifdef RO_FREQ_IRQ_EN
        // Interrupt follows DONE and drops after its W1C
        wr(B0 + 32'h10, 32'h1);
        rd_chk("irq_en_readback", B0 + 32'h10, 32'h1);
        wr(B0 + 32'hC, 32'h6);
        check("irq_idle", {31'd0, irq0}, 0);
        wr(B0, 32'h1);
        wait_done("irq", B0);
        check("irq_set", {31'd0, irq0}, 1);
        wr(B0 + 32'hC, 32'h2);
        check("irq_cleared", {31'd0, irq0}, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
